// File: rtl/asm_fsm.sv
// Three-state ASM controller that tracks runs of consecutive 1s on a serial qualifier.
// y is the registered state code (Moore); z flags a run continuing past two (Mealy).
module asm_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic [1:0] y,
    output logic       z
);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_C   = 2'b10,
        S_ILL = 2'b11
    } state_t;

    // Kept as a plain vector so the illegal code 2'b11 stays representable and observable.
    logic [1:0] state_r;
    logic [1:0] next_s;
    logic       z_s;

    // State register: synchronous reset has priority over the qualifier.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_A;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; the illegal code falls back to idle regardless of the qualifier.
    always_comb begin
        next_s = S_A;
        case (state_r)
            S_A: begin
                if (in) begin
                    next_s = S_B;
                end else begin
                    next_s = S_A;
                end
            end
            S_B: begin
                if (in) begin
                    next_s = S_C;
                end else begin
                    next_s = S_A;
                end
            end
            S_C: begin
                if (in) begin
                    next_s = S_C;
                end else begin
                    next_s = S_A;
                end
            end
            S_ILL: begin
                next_s = S_A;
            end
            default: begin
                next_s = S_A;
            end
        endcase
    end

    // Detect flag: only the registered state and the primary input feed it.
    always_comb begin
        z_s = 1'b0;
        if (state_r == S_C) begin
            z_s = in;
        end else begin
            z_s = 1'b0;
        end
    end

    assign y = state_r;
    assign z = z_s;

endmodule

// File: tb/tb_asm_fsm.sv
// Scoreboard bench for asm_fsm: the driver queues expected {y,z}; monitor loops compare
// after each rising edge and at explicit mid-cycle observation points.
module tb_asm_fsm;

    logic       clk;
    logic       rst;
    logic       in;
    logic [1:0] y;
    logic       z;

    typedef struct {
        logic [1:0] y;
        logic       z;
        string      name;
    } exp_t;

    exp_t sb_edge[$];
    exp_t sb_now[$];
    int   n_cmp;
    int   n_bad;
    event now_ev;

    asm_fsm dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .y   (y),
        .z   (z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void compare(input exp_t e);
        n_cmp = n_cmp + 1;
        if (y !== e.y || z !== e.z) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got y=%b z=%b, expected y=%b z=%b at t=%0t",
                     e.name, y, z, e.y, e.z, $time);
        end
    endfunction

    // Edge monitor: checks registered state a little after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (sb_edge.size() > 0) begin
                compare(sb_edge.pop_front());
            end
        end
    end

    // Immediate monitor: checks the combinational response at driver-chosen instants.
    initial begin
        forever begin
            @(now_ev);
            if (sb_now.size() > 0) begin
                compare(sb_now.pop_front());
            end
        end
    end

    // Drive one cycle of inputs at the falling edge and queue the post-edge expectation.
    task automatic step(input logic in_v, input logic rst_v,
                        input logic [1:0] ey, input logic ez, input string nm);
        exp_t e;
        @(negedge clk);
        in  = in_v;
        rst = rst_v;
        e.y = ey;
        e.z = ez;
        e.name = nm;
        sb_edge.push_back(e);
    endtask

    // Check outputs now, after the current inputs have settled.
    task automatic check_now(input logic [1:0] ey, input logic ez, input string nm);
        exp_t e;
        #1;
        e.y = ey;
        e.z = ez;
        e.name = nm;
        sb_now.push_back(e);
        -> now_ev;
        #1;
    endtask

    typedef struct {
        logic       in_v;
        logic [1:0] ey;
        logic       ez;
    } vec_t;

    vec_t seq[8];

    initial begin
        exp_t e;
        n_cmp = 0;
        n_bad = 0;
        in  = 1'b0;
        rst = 1'b0;

        // Reset, including reset winning over in=1
        step(1'b0, 1'b1, 2'b00, 1'b0, "reset");
        step(1'b1, 1'b1, 2'b00, 1'b0, "reset_with_in1");
        step(1'b0, 1'b0, 2'b00, 1'b0, "idle_after_reset");

        // Run of ones
        step(1'b1, 1'b0, 2'b01, 1'b0, "run_first_one");
        step(1'b1, 1'b0, 2'b10, 1'b1, "run_second_one");
        step(1'b0, 1'b0, 2'b00, 1'b0, "run_drop_edge");
        check_now(2'b10, 1'b0, "run_drop_z_immediate");

        // Broken run
        step(1'b1, 1'b0, 2'b01, 1'b0, "broken_one");
        step(1'b0, 1'b0, 2'b00, 1'b0, "broken_zero");

        // Full sequence after reset
        step(1'b0, 1'b1, 2'b00, 1'b0, "seq_reset");
        seq[0] = '{1'b0, 2'b00, 1'b0};
        seq[1] = '{1'b1, 2'b01, 1'b0};
        seq[2] = '{1'b1, 2'b10, 1'b1};
        seq[3] = '{1'b0, 2'b00, 1'b0};
        seq[4] = '{1'b1, 2'b01, 1'b0};
        seq[5] = '{1'b0, 2'b00, 1'b0};
        seq[6] = '{1'b0, 2'b00, 1'b0};
        seq[7] = '{1'b1, 2'b01, 1'b0};
        for (int i = 0; i < 8; i++) begin
            step(seq[i].in_v, 1'b0, seq[i].ey, seq[i].ez, $sformatf("seq_%0d", i));
        end

        // Long run, then reset while in S_C with in=1
        step(1'b0, 1'b1, 2'b00, 1'b0, "long_reset");
        step(1'b1, 1'b0, 2'b01, 1'b0, "long_b");
        step(1'b1, 1'b0, 2'b10, 1'b1, "long_c");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 2'b10, 1'b1, $sformatf("long_hold_%0d", i));
        end
        step(1'b1, 1'b1, 2'b00, 1'b0, "long_rst_edge");
        check_now(2'b10, 1'b1, "long_rst_z_follows_in");
        step(1'b0, 1'b0, 2'b00, 1'b0, "long_after_rst");

        // Illegal state with in=1, then with in=0
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rst = 1'b0;
            in  = (k == 0) ? 1'b1 : 1'b0;
            force dut.state_r = 2'b11;
            check_now(2'b11, 1'b0, $sformatf("illegal_z_%0d", k));
            release dut.state_r;
            e.y = 2'b00;
            e.z = 1'b0;
            e.name = $sformatf("illegal_recover_%0d", k);
            sb_edge.push_back(e);
        end
        step(1'b1, 1'b0, 2'b01, 1'b0, "post_illegal_b");

        @(negedge clk);
        @(negedge clk);
        n_cmp = n_cmp + 1;
        if (sb_edge.size() != 0 || sb_now.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d/%0d expectations left, expected 0/0",
                     sb_edge.size(), sb_now.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
